// File: rtl/loader_pkg.sv
// Shared opcodes, FSM state encoding and default parameter values for the memory loader.
package loader_pkg;

  localparam int ADDR_W_DEF     = 9;
  localparam int DATA_W_DEF     = 16;
  localparam int WR_HOLD_DEF    = 4;
  localparam int RD_LAT_DEF     = 5;
  localparam int RUN_CYCLES_DEF = 120000;

  localparam logic [3:0] OP_IRAM1 = 4'd1;
  localparam logic [3:0] OP_IRAM2 = 4'd2;
  localparam logic [3:0] OP_DRAM  = 4'd3;
  localparam logic [3:0] OP_RUN   = 4'd4;
  localparam logic [3:0] OP_READ  = 4'd5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_MODE,
    S_GET_DATA,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_POST,
    S_RUN,
    S_RD_PULSE,
    S_RD_OUT,
    S_GAP
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op >= OP_IRAM1) && (op <= OP_READ);
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Loadable down-counter with zero flag; shared by the write pulse, read latency and run phases.
module loader_timer #(
  parameter int W = 17
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_loader.sv
// Host-driven loader: decodes command headers and sequences IRAM/DRAM writes, DRAM readback
// and a timed processor run, one command at a time.
module mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WR_HOLD    = WR_HOLD_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              start,
  output logic              start_2,
  output logic              start_3,
  output logic              start_4,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              iram_write_ext_1,
  output logic              iram_write_ext_2,
  output logic              dram_write_ext,
  output logic              read_en_ext,
  output logic [DATA_W-1:0] Data_in_ins,
  output logic [DATA_W-1:0] Data_in_dram,
  input  logic [DATA_W-1:0] dram_in,
  output logic              busy,
  output logic              err
);

  localparam int TMR_MAX0 = (WR_HOLD > RD_LAT) ? WR_HOLD : RD_LAT;
  localparam int TMR_MAX  = (RUN_CYCLES > TMR_MAX0) ? RUN_CYCLES : TMR_MAX0;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  // Timer counts down to zero, so each phase loads its length minus one.
  localparam logic [TMR_W-1:0] WR_LOAD  = TMR_W'(WR_HOLD - 1);
  localparam logic [TMR_W-1:0] RD_LOAD  = TMR_W'(RD_LAT - 1);
  localparam logic [TMR_W-1:0] RUN_LOAD = TMR_W'(RUN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   ins_q, ins_d;
  logic [DATA_W-1:0]   dram_q, dram_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]    tmr_val;

  logic [3:0]          hdr_op;
  logic [ADDR_W-1:0]   hdr_cnt;
  logic                mode_on;
  logic                unused_hdr;

  assign hdr_op     = in_data[DATA_W-1 -: 4];
  assign hdr_cnt    = in_data[ADDR_W-1:0];
  assign unused_hdr = ^in_data[DATA_W-5:ADDR_W];

  loader_timer #(.W(TMR_W)) u_timer (
    .clock    (clock),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    addr_d   = addr_q;
    ins_d    = ins_q;
    dram_d   = dram_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!op_legal(hdr_op)) begin
            err_d = 1'b1;
          end else if (hdr_op == OP_RUN) begin
            op_d     = hdr_op;
            state_d  = S_RUN;
            tmr_load = 1'b1;
            tmr_val  = RUN_LOAD;
          end else begin
            op_d    = hdr_op;
            cnt_d   = hdr_cnt;
            state_d = S_GET_ADDR;
          end
        end
      end
      S_GET_ADDR: begin
        if (in_valid) begin
          base_d  = in_data[ADDR_W-1:0];
          state_d = S_MODE;
        end
      end
      S_MODE: begin
        addr_d = base_q;
        if (cnt_q == '0) begin
          state_d = S_GAP;
        end else if (op_q == OP_READ) begin
          state_d  = S_RD_PULSE;
          tmr_load = 1'b1;
          tmr_val  = RD_LOAD;
        end else begin
          state_d = S_GET_DATA;
        end
      end
      S_GET_DATA: begin
        if (in_valid) begin
          if (op_q == OP_DRAM) begin
            dram_d = in_data;
          end else begin
            ins_d = in_data;
          end
          state_d = S_WR_SETUP;
        end
      end
      S_WR_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = WR_LOAD;
        state_d  = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (tmr_zero) begin
          state_d = S_WR_POST;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_WR_POST: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - ADDR_W'(1);
        state_d = (cnt_q == ADDR_W'(1)) ? S_GAP : S_GET_DATA;
      end
      S_RUN: begin
        if (tmr_zero) begin
          state_d = S_GAP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_RD_PULSE: begin
        if (tmr_zero) begin
          rdata_d = dram_in;
          state_d = S_RD_OUT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_RD_OUT: begin
        if (out_ready) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) begin
            state_d = S_GAP;
          end else begin
            state_d  = S_RD_PULSE;
            tmr_load = 1'b1;
            tmr_val  = RD_LOAD;
          end
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      ins_q   <= '0;
      dram_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      ins_q   <= ins_d;
      dram_q  <= dram_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Mode strobes cover MODE through the last data/read state and drop in GAP.
  assign mode_on = (state_q == S_MODE)     || (state_q == S_GET_DATA) ||
                   (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) ||
                   (state_q == S_WR_POST)  || (state_q == S_RD_PULSE) ||
                   (state_q == S_RD_OUT);

  // Gated by rst_n so in_ready is also low while reset is held.
  assign in_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_GET_ADDR) ||
                              (state_q == S_GET_DATA));

  assign start            = (state_q == S_RUN);
  assign start_2          = mode_on && ((op_q == OP_IRAM1) || (op_q == OP_IRAM2));
  assign start_3          = mode_on && (op_q == OP_DRAM);
  assign start_4          = mode_on && (op_q == OP_READ);
  assign iram_write_ext_1 = (state_q == S_WR_PULSE) && (op_q == OP_IRAM1);
  assign iram_write_ext_2 = (state_q == S_WR_PULSE) && (op_q == OP_IRAM2);
  assign dram_write_ext   = (state_q == S_WR_PULSE) && (op_q == OP_DRAM);
  assign read_en_ext      = (state_q == S_RD_PULSE);
  assign out_valid        = (state_q == S_RD_OUT);
  assign out_data         = rdata_q;
  assign addr_ext         = addr_q;
  assign Data_in_ins      = ins_q;
  assign Data_in_dram     = dram_q;
  assign busy             = (state_q != S_IDLE);
  assign err              = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: expected write/read events queued per command, checked by a monitor.
module tb_mem_loader;

  localparam int WR_HOLD = 4;
  localparam int RD_LAT  = 5;
  localparam int RUN_N   = 50;

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        start, start_2, start_3, start_4;
  logic [8:0]  addr_ext;
  logic        iram_write_ext_1, iram_write_ext_2, dram_write_ext, read_en_ext;
  logic [15:0] Data_in_ins, Data_in_dram, dram_in;
  logic        busy, err;

  logic [15:0] dram_mem [0:511];

  always #5 clock = ~clock;
  assign dram_in = dram_mem[addr_ext];

  mem_loader #(.ADDR_W(9), .DATA_W(16), .WR_HOLD(WR_HOLD), .RD_LAT(RD_LAT), .RUN_CYCLES(RUN_N)) dut (
    .clock(clock), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
    .addr_ext(addr_ext), .iram_write_ext_1(iram_write_ext_1), .iram_write_ext_2(iram_write_ext_2),
    .dram_write_ext(dram_write_ext), .read_en_ext(read_en_ext),
    .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram), .dram_in(dram_in),
    .busy(busy), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected events: sel 1 = IRAM core1, 2 = IRAM core2, 3 = DRAM.
  typedef struct packed {
    logic [1:0]  sel;
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];

  task automatic expect_writes(input logic [1:0] sel, input int base, input logic [15:0] d[$]);
    for (int i = 0; i < d.size(); i++) begin
      exp_wr.push_back('{sel: sel, addr: 9'((base + i) % 512), data: d[i]});
    end
  endtask

  int          wr_run = 0;
  int          rd_run = 0;
  wr_t         head;
  logic [2:0]  en;
  logic [1:0]  sel_seen;
  logic [15:0] wdata;

  always @(negedge clock) begin : monitor
    if (!rst_n) begin
      exp_wr.delete();
      exp_rd.delete();
      wr_run = 0;
      rd_run = 0;
    end else begin
      if (start | start_2 | start_3 | start_4)
        chk("strobe_onehot", 32'($countones({start, start_2, start_3, start_4})), 32'd1);
      en = {dram_write_ext, iram_write_ext_2, iram_write_ext_1};
      sel_seen = (en == 3'b001) ? 2'd1 : (en == 3'b010) ? 2'd2 : (en == 3'b100) ? 2'd3 : 2'd0;
      wdata = (sel_seen == 2'd3 || (en == 3'b000 && head.sel == 2'd3)) ? Data_in_dram : Data_in_ins;
      if (en != 3'b000) begin
        chk("wr_en_onehot", 32'(sel_seen != 2'd0), 32'd1);
        chk("wr_strobe", 32'((sel_seen == 2'd3) ? start_3 : start_2), 32'd1);
        if (wr_run == 0) begin
          chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
          if (exp_wr.size() != 0) head = exp_wr[0];
          else head = '0;
        end
        chk("wr_sel", 32'(sel_seen), 32'(head.sel));
        chk("wr_addr", 32'(addr_ext), 32'(head.addr));
        chk("wr_data", 32'(wdata), 32'(head.data));
        wr_run++;
      end else if (wr_run != 0) begin
        chk("wr_width", 32'(wr_run), 32'(WR_HOLD));
        chk("wr_post_addr", 32'(addr_ext), 32'(head.addr));
        chk("wr_post_data", 32'(wdata), 32'(head.data));
        if (exp_wr.size() != 0) void'(exp_wr.pop_front());
        wr_run = 0;
      end
      if (read_en_ext) begin
        chk("rd_strobe", 32'(start_4), 32'd1);
        rd_run++;
      end else if (rd_run != 0) begin
        chk("rd_width", 32'(rd_run), 32'(RD_LAT));
        chk("rd_valid_rise", 32'(out_valid), 32'd1);
        rd_run = 0;
      end
      if (out_valid) begin
        chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) begin
          chk("rd_data", 32'(out_data), 32'(exp_rd[0]));
          if (out_ready) void'(exp_rd.pop_front());
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    bit done = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clock);
      if (in_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    chk(name, 32'(busy), 32'd0);
    @(posedge clock);
    #1;
  endtask

  logic any_out;
  assign any_out = |{out_data, out_valid, in_ready, start, start_2, start_3, start_4, addr_ext,
                     iram_write_ext_1, iram_write_ext_2, dram_write_ext, read_en_ext,
                     Data_in_ins, Data_in_dram, busy, err};

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    bit seen;
    for (int i = 0; i < 512; i++) dram_mem[i] = 16'(i * 3);
    dram_mem[20] = 16'h1234;
    dram_mem[21] = 16'hBEEF;

    // Reset state
    #1 rst_n = 1'b0;
    #2 chk("reset_outputs_zero", 32'(any_out), 32'd0);
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(posedge clock);
    #1;

    // IRAM core1 load of three words at 10..12
    expect_writes(2'd1, 10, '{16'd7, 16'd8, 16'd9});
    send_word(16'h1003);
    send_word(16'd10);
    send_word(16'd7);
    send_word(16'd8);
    send_word(16'd9);
    wait_idle("iram1_idle");
    chk("iram1_all_writes", 32'(exp_wr.size()), 32'd0);
    chk("iram1_hold_data", 32'(Data_in_ins), 32'h0009);

    // DRAM readback of 20..21 with host stalling the first word
    exp_rd.push_back(16'h1234);
    exp_rd.push_back(16'hBEEF);
    out_ready = 1'b0;
    send_word(16'h5002);
    send_word(16'd20);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    chk("rd_first_valid", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("rd_stall_valid", 32'(out_valid), 32'd1);
      chk("rd_stall_data", 32'(out_data), 32'h1234);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    wait_idle("rd_idle");
    chk("rd_all_words", 32'(exp_rd.size()), 32'd0);
    chk("rd_last_data", 32'(out_data), 32'hBEEF);

    // Run command: start width, one GAP cycle, then idle
    send_word(16'h4000);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!start) break;
      cnt++;
    end
    chk("run_width", 32'(cnt), 32'd50);
    chk("run_gap_busy", 32'(busy), 32'd1);
    chk("run_gap_strobes", 32'({start, start_2, start_3, start_4}), 32'd0);
    @(negedge clock);
    chk("run_after_gap_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;

    // DRAM load wrapping 511 -> 0
    expect_writes(2'd3, 511, '{16'hAAAA, 16'h5555});
    send_word(16'h3002);
    send_word(16'd511);
    send_word(16'hAAAA);
    send_word(16'h5555);
    wait_idle("dram_idle");
    chk("dram_all_writes", 32'(exp_wr.size()), 32'd0);
    chk("dram_hold_data", 32'(Data_in_dram), 32'h5555);
    chk("ins_untouched", 32'(Data_in_ins), 32'h0009);

    // Illegal opcode, then a normal core2 load, then a zero-count load
    send_word(16'h7000);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_stays_idle", 32'(busy), 32'd0);
    chk("illegal_no_strobe", 32'({start, start_2, start_3, start_4}), 32'd0);
    expect_writes(2'd2, 5, '{16'h0077});
    send_word(16'h2001);
    send_word(16'd5);
    send_word(16'h0077);
    wait_idle("iram2_idle");
    chk("iram2_all_writes", 32'(exp_wr.size()), 32'd0);
    send_word(16'h2000);
    send_word(16'd3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (start_2) cnt++;
      if (!busy) break;
    end
    chk("zero_count_start2_cycles", 32'(cnt), 32'd1);
    chk("zero_count_idle", 32'(busy), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    @(posedge clock);
    #1;

    // Reset during the second cycle of a write pulse
    expect_writes(2'd1, 30, '{16'h1111});
    send_word(16'h1002);
    send_word(16'd30);
    send_word(16'h1111);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (iram_write_ext_1) seen = 1'b1;
    end
    chk("abort_pulse_seen", 32'(seen), 32'd1);
    @(posedge clock);
    #1;
    chk("abort_pulse_second_cycle", 32'(iram_write_ext_1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", 32'(any_out), 32'd0);
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_err_cleared", 32'(err), 32'd0);
    repeat (10) @(posedge clock);
    #1;
    expect_writes(2'd1, 40, '{16'h2222});
    send_word(16'h1001);
    send_word(16'd40);
    send_word(16'h2222);
    wait_idle("post_reset_idle");
    chk("post_reset_writes", 32'(exp_wr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
